// File: rtl/red_pitaya_xadc_drp_arb_if.sv
// System-bus request/acknowledge bundle shared between the bus master and the DRP arbiter.
// The bus master drives requests; the arbiter answers with ack, error and read data.
interface red_pitaya_xadc_drp_arb_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (
    output sys_addr,
    output sys_wdata,
    output sys_wen,
    output sys_ren,
    input  sys_rdata,
    input  sys_ack,
    input  sys_err
  );

  modport slave (
    input  sys_addr,
    input  sys_wdata,
    input  sys_wen,
    input  sys_ren,
    output sys_rdata,
    output sys_ack,
    output sys_err
  );
endinterface

// File: rtl/red_pitaya_xadc_drp_arb.sv
// Shares the XADC DRP port between automatic end-of-conversion readback and system-bus
// access to any DRP register; one DRP transaction outstanding at a time.
module red_pitaya_xadc_drp_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        xadc_eoc_i,
  input  logic [4:0]  xadc_channel_i,
  output logic [6:0]  drp_addr_o,
  output logic        drp_en_o,
  output logic        drp_we_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_rdy_i,
  output logic        smp_vld_o,
  output logic [4:0]  smp_ch_o,
  output logic [11:0] smp_dat_o,
  red_pitaya_xadc_drp_arb_if.slave sys
);

  typedef enum logic [1:0] {StIdle, StWaitAuto, StWaitBus} state_e;

  localparam logic [7:0] LpWaitLast = 8'(TIMEOUT - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e      r_state, w_state_d;
  logic [7:0]  r_wait_cnt, w_wait_cnt_d;
  logic        r_bus_prio, w_bus_prio_d;
  logic [4:0]  r_cur_ch, w_cur_ch_d;
  logic        r_auto_full, w_auto_full_d;
  logic [4:0]  r_auto_ch, w_auto_ch_d;
  logic        r_bus_full, w_bus_full_d;
  logic [6:0]  r_bus_addr, w_bus_addr_d;
  logic        r_bus_we, w_bus_we_d;
  logic [15:0] r_bus_wdata, w_bus_wdata_d;
  logic [15:0] r_ovr_cnt, w_ovr_cnt_d;
  logic [15:0] r_to_cnt, w_to_cnt_d;
  logic        r_drp_en, w_drp_en_d;
  logic        r_drp_we, w_drp_we_d;
  logic [6:0]  r_drp_addr, w_drp_addr_d;
  logic [15:0] r_drp_di, w_drp_di_d;
  logic        r_smp_vld, w_smp_vld_d;
  logic [4:0]  r_smp_ch, w_smp_ch_d;
  logic [11:0] r_smp_dat, w_smp_dat_d;
  logic        r_sys_ack, w_sys_ack_d;
  logic        r_sys_err, w_sys_err_d;
  logic [31:0] r_sys_rdata, w_sys_rdata_d;

  logic        w_req, w_drp_space, w_stat, w_accept, w_bus_new;
  logic        w_auto_pend, w_bus_pend, w_auto_take, w_bus_take;
  logic [4:0]  w_auto_ch_eff;
  logic [6:0]  w_bus_addr_eff;
  logic        w_bus_we_eff;
  logic [15:0] w_bus_wdata_eff;
  logic        w_unused;

  assign w_req       = sys.sys_wen | sys.sys_ren;
  assign w_drp_space = (sys.sys_addr[19:9] == 11'd0);
  assign w_stat      = (sys.sys_addr[19:0] == 20'h00200);
  // A bus transaction in flight counts as an occupied slot so acks can never collide.
  assign w_accept    = w_req && !r_bus_full && (r_state != StWaitBus);
  assign w_bus_new   = w_accept && w_drp_space;

  // Fresh requests bypass the empty slot so the DRP enable follows the request by one edge.
  assign w_auto_pend     = r_auto_full | xadc_eoc_i;
  assign w_auto_ch_eff   = r_auto_full ? r_auto_ch : xadc_channel_i;
  assign w_bus_pend      = r_bus_full | w_bus_new;
  assign w_bus_addr_eff  = r_bus_full ? r_bus_addr : sys.sys_addr[8:2];
  assign w_bus_we_eff    = r_bus_full ? r_bus_we : sys.sys_wen;
  assign w_bus_wdata_eff = r_bus_full ? r_bus_wdata : sys.sys_wdata[15:0];

  assign w_unused = ^{sys.sys_addr[31:20], sys.sys_addr[1:0], sys.sys_wdata[31:16]};

  always_comb begin
    w_state_d     = r_state;
    w_wait_cnt_d  = r_wait_cnt;
    w_bus_prio_d  = r_bus_prio;
    w_cur_ch_d    = r_cur_ch;
    w_auto_full_d = r_auto_full;
    w_auto_ch_d   = r_auto_ch;
    w_bus_full_d  = r_bus_full;
    w_bus_addr_d  = r_bus_addr;
    w_bus_we_d    = r_bus_we;
    w_bus_wdata_d = r_bus_wdata;
    w_ovr_cnt_d   = r_ovr_cnt;
    w_to_cnt_d    = r_to_cnt;
    w_drp_en_d    = 1'b0;
    w_drp_we_d    = r_drp_we;
    w_drp_addr_d  = r_drp_addr;
    w_drp_di_d    = r_drp_di;
    w_smp_vld_d   = 1'b0;
    w_smp_ch_d    = r_smp_ch;
    w_smp_dat_d   = r_smp_dat;
    w_sys_ack_d   = 1'b0;
    w_sys_err_d   = 1'b0;
    w_sys_rdata_d = 32'd0;
    w_auto_take   = 1'b0;
    w_bus_take    = 1'b0;

    case (r_state)
      StIdle: begin
        // Auto wins unless the previous transaction was an auto one and the bus is waiting.
        if (w_auto_pend && (!w_bus_pend || !r_bus_prio)) begin
          w_auto_take  = 1'b1;
          w_drp_en_d   = 1'b1;
          w_drp_we_d   = 1'b0;
          w_drp_addr_d = {2'b00, w_auto_ch_eff};
          w_cur_ch_d   = w_auto_ch_eff;
          w_bus_prio_d = 1'b0;
          w_wait_cnt_d = 8'd0;
          w_state_d    = StWaitAuto;
        end else if (w_bus_pend) begin
          w_bus_take   = 1'b1;
          w_drp_en_d   = 1'b1;
          w_drp_we_d   = w_bus_we_eff;
          w_drp_addr_d = w_bus_addr_eff;
          w_drp_di_d   = w_bus_wdata_eff;
          w_bus_prio_d = 1'b0;
          w_wait_cnt_d = 8'd0;
          w_state_d    = StWaitBus;
        end
      end
      StWaitAuto: begin
        if (drp_rdy_i) begin
          w_smp_vld_d  = 1'b1;
          w_smp_ch_d   = r_cur_ch;
          w_smp_dat_d  = drp_do_i[15:4];
          w_bus_prio_d = 1'b1;
          w_state_d    = StIdle;
        end else if (r_wait_cnt == LpWaitLast) begin
          w_to_cnt_d   = sat_inc(r_to_cnt);
          w_bus_prio_d = 1'b1;
          w_state_d    = StIdle;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 8'd1;
        end
      end
      StWaitBus: begin
        if (drp_rdy_i) begin
          w_sys_ack_d   = 1'b1;
          w_sys_rdata_d = r_drp_we ? 32'd0 : {16'h0000, drp_do_i};
          w_state_d     = StIdle;
        end else if (r_wait_cnt == LpWaitLast) begin
          w_sys_ack_d = 1'b1;
          w_sys_err_d = 1'b1;
          w_to_cnt_d  = sat_inc(r_to_cnt);
          w_state_d   = StIdle;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 8'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    // An EOC in the cycle the slot is consumed refills it without counting an overrun.
    if (xadc_eoc_i) begin
      if (r_auto_full && !w_auto_take) begin
        w_ovr_cnt_d = sat_inc(r_ovr_cnt);
      end
      if (!(w_auto_take && !r_auto_full)) begin
        w_auto_full_d = 1'b1;
        w_auto_ch_d   = xadc_channel_i;
      end
    end else if (w_auto_take) begin
      w_auto_full_d = 1'b0;
    end

    if (w_bus_take) begin
      w_bus_full_d = 1'b0;
    end else if (w_bus_new) begin
      w_bus_full_d  = 1'b1;
      w_bus_addr_d  = sys.sys_addr[8:2];
      w_bus_we_d    = sys.sys_wen;
      w_bus_wdata_d = sys.sys_wdata[15:0];
    end

    if (w_accept && !w_drp_space) begin
      w_sys_ack_d   = 1'b1;
      w_sys_rdata_d = (w_stat && sys.sys_ren) ? {r_ovr_cnt, r_to_cnt} : 32'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= StIdle;
      r_wait_cnt  <= 8'd0;
      r_bus_prio  <= 1'b0;
      r_cur_ch    <= 5'd0;
      r_auto_full <= 1'b0;
      r_auto_ch   <= 5'd0;
      r_bus_full  <= 1'b0;
      r_bus_addr  <= 7'd0;
      r_bus_we    <= 1'b0;
      r_bus_wdata <= 16'd0;
      r_ovr_cnt   <= 16'd0;
      r_to_cnt    <= 16'd0;
      r_drp_en    <= 1'b0;
      r_drp_we    <= 1'b0;
      r_drp_addr  <= 7'd0;
      r_drp_di    <= 16'd0;
      r_smp_vld   <= 1'b0;
      r_smp_ch    <= 5'd0;
      r_smp_dat   <= 12'd0;
      r_sys_ack   <= 1'b0;
      r_sys_err   <= 1'b0;
      r_sys_rdata <= 32'd0;
    end else begin
      r_state     <= w_state_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_bus_prio  <= w_bus_prio_d;
      r_cur_ch    <= w_cur_ch_d;
      r_auto_full <= w_auto_full_d;
      r_auto_ch   <= w_auto_ch_d;
      r_bus_full  <= w_bus_full_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_we    <= w_bus_we_d;
      r_bus_wdata <= w_bus_wdata_d;
      r_ovr_cnt   <= w_ovr_cnt_d;
      r_to_cnt    <= w_to_cnt_d;
      r_drp_en    <= w_drp_en_d;
      r_drp_we    <= w_drp_we_d;
      r_drp_addr  <= w_drp_addr_d;
      r_drp_di    <= w_drp_di_d;
      r_smp_vld   <= w_smp_vld_d;
      r_smp_ch    <= w_smp_ch_d;
      r_smp_dat   <= w_smp_dat_d;
      r_sys_ack   <= w_sys_ack_d;
      r_sys_err   <= w_sys_err_d;
      r_sys_rdata <= w_sys_rdata_d;
    end
  end

  assign drp_en_o      = r_drp_en;
  assign drp_we_o      = r_drp_we;
  assign drp_addr_o    = r_drp_addr;
  assign drp_di_o      = r_drp_di;
  assign smp_vld_o     = r_smp_vld;
  assign smp_ch_o      = r_smp_ch;
  assign smp_dat_o     = r_smp_dat;
  assign sys.sys_ack   = r_sys_ack;
  assign sys.sys_err   = r_sys_err;
  assign sys.sys_rdata = r_sys_rdata;

endmodule
